// File: rtl/uart_stack_buffer.sv
// uart_stack_buffer: circular byte store between uart_rx and uart_tx.
// Words are collected while filling. A drain starts when the store fills, on
// a terminator byte, or on flush. The drain order (FIFO/LIFO) is latched when
// the drain starts. Each word handed to uart_tx waits for that transmitter's
// busy rise and fall before the next word is offered.
module uart_stack_buffer #(
  parameter int                      PAYLOAD_BITS = 8,
  parameter int                      DEPTH        = 64,
  parameter int                      TERM_EN      = 1,
  parameter logic [PAYLOAD_BITS-1:0] TERMINATOR   = 8'h0D,
  parameter int                      COUNT_W      = $clog2(DEPTH + 1)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    mode,
  input  logic                    flush,
  input  logic                    rx_valid,
  input  logic [PAYLOAD_BITS-1:0] rx_data,
  input  logic                    tx_busy,
  output logic                    tx_en,
  output logic [PAYLOAD_BITS-1:0] tx_data,
  output logic [COUNT_W-1:0]      count,
  output logic                    full,
  output logic                    empty,
  output logic                    sending,
  output logic                    overflow
);

  localparam int                 PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [COUNT_W-1:0] L_DEPTH  = COUNT_W'(DEPTH);
  localparam logic [COUNT_W:0]   L_DEPTHX = (COUNT_W + 1)'(DEPTH);
  localparam logic [PTR_W-1:0]   L_LAST   = PTR_W'(DEPTH - 1);

  typedef enum logic [1:0] {
    S_FILL      = 2'd0,
    S_SEND      = 2'd1,
    S_WAIT_ACK  = 2'd2,
    S_WAIT_DONE = 2'd3
  } state_t;

  state_t                    r_state;
  state_t                    w_next;
  logic [PAYLOAD_BITS-1:0]   r_mem [0:DEPTH-1];
  logic [PTR_W-1:0]          r_wp;
  logic [COUNT_W-1:0]        r_count;
  logic                      r_overflow;
  logic                      r_mode;

  logic                      w_wr;
  logic                      w_drop;
  logic [COUNT_W-1:0]        w_cnt_after;
  logic                      w_trigger;
  logic [PTR_W-1:0]          w_wp_inc;
  logic [PTR_W-1:0]          w_wp_dec;
  logic [COUNT_W:0]          w_head_sum;
  logic [COUNT_W:0]          w_head_mod;
  logic [PTR_W-1:0]          w_head;
  logic [PTR_W-1:0]          w_rd_idx;

  // Write/trigger decode for the fill phase; anything arriving while draining is dropped.
  always_comb begin
    w_wr        = (r_state == S_FILL) && rx_valid && (r_count != L_DEPTH);
    w_drop      = rx_valid && !w_wr;
    w_cnt_after = r_count + COUNT_W'(w_wr);
    w_trigger   = (r_state == S_FILL) &&
                  ((w_cnt_after == L_DEPTH) ||
                   ((TERM_EN != 0) && rx_valid && (rx_data == TERMINATOR)) ||
                   (flush && (w_cnt_after != {COUNT_W{1'b0}})));
  end

  // Pointer arithmetic: wrap-around neighbours of wp and the FIFO head (wp - count mod DEPTH).
  always_comb begin
    w_wp_inc   = (r_wp == L_LAST) ? {PTR_W{1'b0}} : r_wp + {{(PTR_W-1){1'b0}}, 1'b1};
    w_wp_dec   = (r_wp == {PTR_W{1'b0}}) ? L_LAST : r_wp - {{(PTR_W-1){1'b0}}, 1'b1};
    w_head_sum = (COUNT_W + 1)'(r_wp) + L_DEPTHX - {1'b0, r_count};
    if (w_head_sum >= L_DEPTHX) begin
      w_head_mod = w_head_sum - L_DEPTHX;
    end else begin
      w_head_mod = w_head_sum;
    end
    w_head   = PTR_W'(w_head_mod);
    w_rd_idx = r_mode ? w_wp_dec : w_head;
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_FILL;
    end else begin
      r_state <= w_next;
    end
  end

  // FSM next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FILL: begin
        if (w_trigger) begin
          w_next = S_SEND;
        end else begin
          w_next = S_FILL;
        end
      end
      S_SEND: begin
        if (!tx_busy) begin
          w_next = S_WAIT_ACK;
        end else begin
          w_next = S_SEND;
        end
      end
      S_WAIT_ACK: begin
        if (tx_busy) begin
          w_next = S_WAIT_DONE;
        end else begin
          w_next = S_WAIT_ACK;
        end
      end
      S_WAIT_DONE: begin
        if (!tx_busy) begin
          w_next = (r_count != {COUNT_W{1'b0}}) ? S_SEND : S_FILL;
        end else begin
          w_next = S_WAIT_DONE;
        end
      end
      default: w_next = S_FILL;
    endcase
  end

  // FSM outputs: one send strobe per SEND visit, gated by the transmitter being idle.
  always_comb begin
    tx_en   = 1'b0;
    tx_data = {PAYLOAD_BITS{1'b0}};
    sending = 1'b0;
    case (r_state)
      S_FILL: begin
        sending = 1'b0;
      end
      S_SEND: begin
        sending = 1'b1;
        tx_en   = !tx_busy;
        if (!tx_busy) begin
          tx_data = r_mem[w_rd_idx];
        end else begin
          tx_data = {PAYLOAD_BITS{1'b0}};
        end
      end
      S_WAIT_ACK, S_WAIT_DONE: begin
        sending = 1'b1;
      end
      default: begin
        sending = 1'b0;
      end
    endcase
  end

  // Occupancy, write pointer, sticky overflow and the order latched at drain start.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wp       <= {PTR_W{1'b0}};
      r_count    <= {COUNT_W{1'b0}};
      r_overflow <= 1'b0;
      r_mode     <= 1'b0;
    end else begin
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
      if (w_wr) begin
        r_wp    <= w_wp_inc;
        r_count <= w_cnt_after;
      end else if (tx_en) begin
        r_count <= r_count - {{(COUNT_W-1){1'b0}}, 1'b1};
        if (r_mode) begin
          r_wp <= w_wp_dec;
        end
      end
      if (w_trigger) begin
        r_mode <= mode;
      end
    end
  end

  // Storage array; contents intentionally survive reset.
  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wp] <= rx_data;
    end
  end

  assign count    = r_count;
  assign full     = (r_count == L_DEPTH);
  assign empty    = (r_count == {COUNT_W{1'b0}});
  assign overflow = r_overflow;

endmodule

// File: tb/tb_uart_stack_buffer.sv
// Bench for uart_stack_buffer (DEPTH=4, terminator 0x0D). The reference is a
// queue of stored words; the drain order is that queue or its reverse. A small
// transmitter model answers each tx_en with a delayed busy pulse.
module tb_uart_stack_buffer;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          reset, mode, flush, rx_valid, tx_busy;
  logic [7:0]    rx_data;
  logic          tx_en;
  logic [7:0]    tx_data;
  logic [CW-1:0] count;
  logic          full, empty, sending, overflow;

  int            n_tests = 0;
  int            n_fail  = 0;
  logic [7:0]    m_q [$];
  bit            m_ovf;
  bit            m_mode;

  uart_stack_buffer #(
    .PAYLOAD_BITS(8), .DEPTH(DEPTH), .TERM_EN(1), .TERMINATOR(8'h0D)
  ) dut (
    .clk(clk), .reset(reset), .mode(mode), .flush(flush),
    .rx_valid(rx_valid), .rx_data(rx_data), .tx_busy(tx_busy),
    .tx_en(tx_en), .tx_data(tx_data), .count(count), .full(full),
    .empty(empty), .sending(sending), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic check_status(input string tag, input bit exp_sending);
    chk({tag, "_count"},    32'(count),    32'(m_q.size()));
    chk({tag, "_full"},     32'(full),     32'(m_q.size() == DEPTH));
    chk({tag, "_empty"},    32'(empty),    32'(m_q.size() == 0));
    chk({tag, "_sending"},  32'(sending),  32'(exp_sending));
    chk({tag, "_overflow"}, 32'(overflow), 32'(m_ovf));
  endtask

  function automatic logic [7:0] rnd_byte();
    logic [7:0] b;
    do b = 8'($urandom); while (b == 8'h0D);
    return b;
  endfunction

  // Deliver one received word while filling; exp_trig says whether it must start a drain.
  task automatic push_word(input logic [7:0] b, input bit exp_trig);
    rx_valid = 1'b1;
    rx_data  = b;
    next_cycle();
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    if (m_q.size() < DEPTH) m_q.push_back(b);
    else m_ovf = 1'b1;
    check_status("fill", exp_trig);
    chk("fill_tx_en", 32'(tx_en), 32'(exp_trig));
  endtask

  // Act as uart_tx until the drain finishes (or stop_after words were sent).
  task automatic drain(input int stop_after, input int inject_pct,
                       input int min_hold, input int max_hold);
    logic [7:0] exp_q [$];
    int n, k, busy_cnt, ack_delay, cyc;
    bit gap, seen, inj, idle_seen;
    exp_q = {};
    if (m_mode) begin
      for (int i = m_q.size() - 1; i >= 0; i--) exp_q.push_back(m_q[i]);
    end else begin
      exp_q = m_q;
    end
    n = exp_q.size(); k = 0; cyc = 0; ack_delay = 0; idle_seen = 1'b0;
    busy_cnt = $urandom_range(0, 2);
    forever begin
      gap     = (ack_delay > 0);
      tx_busy = !gap && (busy_cnt > 0);
      inj     = ($urandom_range(0, 99) < inject_pct);
      if (inj) begin
        rx_valid = 1'b1;
        rx_data  = 8'h99;
      end
      #1;
      seen = tx_en;
      chk("drain_count", 32'(count), 32'(n - k));
      chk("drain_overflow", 32'(overflow), 32'(m_ovf));
      if (seen) begin
        chk("tx_guard", {30'd0, tx_busy, gap}, 32'd0);
        if (k < n) chk("tx_data", 32'(tx_data), 32'(exp_q[k]));
        else chk("extra_tx_en", 32'd1, 32'd0);
        k++;
        ack_delay = $urandom_range(0, 2);
        busy_cnt  = $urandom_range(min_hold, max_hold);
      end else begin
        chk("tx_data_idle", 32'(tx_data), 32'd0);
        if (k < n || tx_busy || gap) begin
          chk("sending_hold", 32'(sending), 32'd1);
        end else if (!idle_seen) begin
          chk("sending_last", 32'(sending), 32'd1);
          idle_seen = 1'b1;
        end else begin
          chk("sending_end", 32'(sending), 32'd0);
          break;
        end
        if (gap) ack_delay--;
        else if (busy_cnt > 0) busy_cnt--;
      end
      if (inj) m_ovf = 1'b1;
      @(posedge clk);
      #1;
      rx_valid = 1'b0;
      rx_data  = 8'h00;
      if (stop_after > 0 && k >= stop_after) break;
      cyc++;
      if (cyc > 2000) begin
        chk("drain_timeout", 32'd1, 32'd0);
        break;
      end
    end
    rx_valid = 1'b0;
    tx_busy  = 1'b0;
    if (stop_after == 0) m_q.delete();
  endtask

  task automatic fill_fixed(input bit md);
    m_mode = md;
    mode   = md;
    push_word(8'h11, 1'b0);
    push_word(8'h22, 1'b0);
    push_word(8'h33, 1'b0);
    push_word(8'h44, 1'b1);
    mode = ~md;
  endtask

  task automatic run_random(input int kind);
    int n;
    m_mode = 1'($urandom_range(0, 1));
    mode   = m_mode;
    case (kind)
      0: begin
        for (int i = 0; i < DEPTH; i++) push_word(rnd_byte(), i == DEPTH - 1);
      end
      1: begin
        n = $urandom_range(1, DEPTH - 1);
        for (int i = 0; i < n - 1; i++) push_word(rnd_byte(), 1'b0);
        push_word(8'h0D, 1'b1);
      end
      default: begin
        n = $urandom_range(1, DEPTH - 1);
        for (int i = 0; i < n; i++) push_word(rnd_byte(), 1'b0);
        flush = 1'b1;
        next_cycle();
        flush = 1'b0;
        check_status("flush", 1'b1);
        chk("flush_tx_en", 32'(tx_en), 32'd1);
      end
    endcase
    mode = ~m_mode;
    drain(0, 10, 1, 4);
    check_status("rnd_done", 1'b0);
  endtask

  initial begin
    reset = 1'b1; mode = 1'b0; flush = 1'b0; rx_valid = 1'b0;
    rx_data = 8'h00; tx_busy = 1'b0; m_ovf = 1'b0; m_mode = 1'b0;
    repeat (3) next_cycle();
    reset = 1'b0;
    check_status("reset", 1'b0);
    chk("reset_tx_en", 32'(tx_en), 32'd0);
    chk("reset_tx_data", 32'(tx_data), 32'd0);

    // FIFO then LIFO of the same four words.
    fill_fixed(1'b0);
    drain(0, 0, 1, 3);
    check_status("fifo_done", 1'b0);
    fill_fixed(1'b1);
    drain(0, 0, 1, 3);
    check_status("lifo_done", 1'b0);

    // Terminator trigger.
    m_mode = 1'b0; mode = 1'b0;
    push_word(8'h41, 1'b0);
    push_word(8'h42, 1'b0);
    push_word(8'h0D, 1'b1);
    drain(0, 0, 1, 2);
    check_status("term_done", 1'b0);

    // Flush with one word, then flush with nothing stored.
    push_word(8'h55, 1'b0);
    flush = 1'b1;
    next_cycle();
    flush = 1'b0;
    check_status("flush1", 1'b1);
    drain(0, 0, 1, 2);
    flush = 1'b1;
    next_cycle();
    flush = 1'b0;
    check_status("flush0", 1'b0);
    chk("flush0_tx_en", 32'(tx_en), 32'd0);
    next_cycle();
    check_status("flush0_idle", 1'b0);
    chk("flush0_idle_tx_en", 32'(tx_en), 32'd0);

    // Dropped words while draining, with a long transmitter busy time.
    fill_fixed(1'b0);
    drain(0, 40, 20, 20);
    check_status("ovf_done", 1'b0);

    for (int it = 0; it < 30; it++) run_random($urandom_range(0, 2));

    // Reset in the middle of a drain.
    fill_fixed(1'b1);
    drain(2, 100, 1, 3);
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    tx_busy = 1'b0;
    m_q.delete();
    m_ovf = 1'b0;
    #1;
    chk("midreset_tx_en", 32'(tx_en), 32'd0);
    chk("midreset_tx_data", 32'(tx_data), 32'd0);
    check_status("midreset", 1'b0);
    next_cycle();
    chk("midreset_idle_tx_en", 32'(tx_en), 32'd0);
    fill_fixed(1'b0);
    drain(0, 0, 1, 3);
    check_status("after_reset", 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_stack_buffer.md
Name: uart_stack_buffer

Overview:
Parametrised byte buffer between uart_rx and uart_tx. It collects received payloads in a circular store of DEPTH entries, then drains them to the transmitter in FIFO or LIFO order. A drain starts on any of three triggers: the store is full, a terminator byte arrives, or an explicit flush. It generalises the fixed-depth, LIFO-only, drain-when-full echo stack with selectable order, terminator/flush triggers, occupancy/overflow status and a safe transmitter handshake.

Parameters:
PAYLOAD_BITS, 8, width of each stored word and of rx/tx data.
DEPTH, 64, number of storage entries; any value >= 2, not required to be a power of two.
TERM_EN, 1, 1 enables the terminator trigger.
TERMINATOR, 8'h0D, payload value that triggers a drain when TERM_EN=1.
COUNT_W, $clog2(DEPTH+1), width of the count output.

Ports:
clk  input  1  system clock, all logic on posedge.
reset  input  1  synchronous, active-high reset.
mode  input  1  drain order: 0=FIFO (oldest first), 1=LIFO (newest first); sampled at drain start.
flush  input  1  single-cycle request to drain current contents.
rx_valid  input  1  one-cycle strobe from uart_rx: rx_data valid.
rx_data  input  PAYLOAD_BITS  received word.
tx_busy  input  1  uart_tx busy.
tx_en  output  1  one-cycle send strobe to uart_tx.
tx_data  output  PAYLOAD_BITS  word to send; valid when tx_en=1, else 0.
count  output  COUNT_W  entries currently stored.
full  output  1  count==DEPTH.
empty  output  1  count==0.
sending  output  1  high while a drain is in progress.
overflow  output  1  sticky: a received word was dropped.

Behaviour:
- Reset (sync, on the clk edge with reset=1): state=FILL, write/read pointers=0, count=0, tx_en=0, tx_data=0, sending=0, overflow=0, latched mode=0. Storage contents are not cleared. A reset during a drain aborts it immediately, and no further tx_en is issued.
- Storage is a circular array. The write pointer wp wraps DEPTH-1 -> 0. FIFO reads at head; LIFO reads at (wp-1) with wrap.
- States: FILL, SEND, WAIT_ACK, WAIT_DONE.
- FILL:
  - rx_valid with count<DEPTH: write the word at wp, increment wp and count at that edge.
  - rx_valid with count==DEPTH: drop the word, set overflow.
  - Trigger is evaluated on the same edge, after the write is accounted for. Trigger = (count after write == DEPTH) OR (TERM_EN and rx_valid and rx_data==TERMINATOR) OR (flush and count after write > 0).
  - On trigger: latch mode, go to SEND, sending=1.
  - flush with count==0 and no rx_valid is ignored.
- SEND: when tx_busy=0, assert tx_en for exactly one cycle with tx_data = selected entry. On that edge decrement count, advance the read side (FIFO head+1, LIFO wp-1), and go to WAIT_ACK. While tx_busy=1, hold in SEND with tx_en=0.
- WAIT_ACK: wait for tx_busy=1, then go to WAIT_DONE. This guarantees no second tx_en before the transmitter registers the first.
- WAIT_DONE: wait for tx_busy=0. Then go to SEND if count>0; otherwise go to FILL and clear sending.
- Latency: the trigger edge sets SEND. tx_en rises in the cycle after the trigger edge if tx_busy=0.
- During a drain (sending=1), rx_valid words are dropped and set overflow. flush is ignored. mode changes have no effect until the next drain.
- overflow clears only on reset.
- FIFO drain returns words in arrival order. LIFO drain returns them in reverse.
- Pointer rules: in FIFO mode, head == wp - count (mod DEPTH). After a LIFO drain completes, wp returns to the value it had before the drained words were written.

Test Plan:
- DEPTH=4, mode=0, rx 0x11,0x22,0x33,0x44 -> full=1 at 4th write, then tx_en pulses with tx_data 0x11,0x22,0x33,0x44 in order; count ends at 0; sending falls after the last tx_busy falling edge.
- DEPTH=4, mode=1, same stimulus -> tx_data order 0x44,0x33,0x22,0x11.
- DEPTH=8, TERM_EN=1: rx 0x41,0x42,0x0D -> drain of 3 words 0x41,0x42,0x0D (FIFO); no trigger for earlier words.
- DEPTH=8: rx 0x55 then flush with count=1 -> a single tx_en with tx_data=0x55. flush with count=0 -> no tx_en, sending stays 0.
- DEPTH=4, full and draining: rx_valid with 0x99 during SEND/WAIT states -> word dropped, overflow=1 and stays 1; drained data is unaffected. Hold tx_busy=1 for 20 cycles after tx_en -> exactly one tx_en per tx_busy rise/fall pair.
- Mid-drain reset after 2 of 4 words sent -> next cycle tx_en=0, count=0, sending=0, overflow=0; subsequent rx fill/drain behaves as from power-on.
